// File: rtl/adder_pipe.sv
// adder_pipe: pipelined ripple-carry add/subtract unit.
// One CW-bit carry chunk is resolved per stage; the pipe stalls as a whole.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  logic              adv;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;

  // registered stage state
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             ovf_q;
  logic             zero_q;

  // per-stage inputs and next values
  logic [WIDTH-1:0] ia [STAGES];
  logic [WIDTH-1:0] ib [STAGES];
  logic [WIDTH-1:0] is [STAGES];
  logic             ic [STAGES];
  logic [WIDTH-1:0] s_n [STAGES];
  logic             c_n [STAGES];
  logic             ovf_n;
  logic             zero_n;

  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;
  assign adv      = ~vld[STAGES-1] | out_ready;
  assign in_ready = adv;

  // stage inputs: stage 0 sees the ports, stage k sees stage k-1 registers
  always_comb begin
    ia[0] = a;
    ib[0] = b_eff;
    ic[0] = c0;
    is[0] = '0;
    ld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ia[k] = a_q[k-1];
      ib[k] = b_q[k-1];
      ic[k] = c_q[k-1];
      is[k] = s_q[k-1];
      ld[k] = vld[k-1];
    end
  end

  // one CW-bit ripple chunk per stage, flags from the final chunk
  always_comb begin
    logic [CW:0] t;
    t      = '0;
    ovf_n  = 1'b0;
    zero_n = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, ia[k][k*CW +: CW]}
        + {1'b0, ib[k][k*CW +: CW]}
        + {{CW{1'b0}}, ic[k]};
      s_n[k] = is[k];
      s_n[k][k*CW +: CW] = t[CW-1:0];
      c_n[k] = t[CW];
      if (k == STAGES - 1) begin
        ovf_n  = ia[k][WIDTH-1] ^ ib[k][WIDTH-1]
               ^ s_n[k][WIDTH-1] ^ t[CW];
        zero_n = (s_n[k] == '0);
      end
    end
  end

  // advance all stages together; data only loads behind a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld[k] <= ld[k];
        if (ld[k]) begin
          a_q[k] <= ia[k];
          b_q[k] <= ib[k];
          s_q[k] <= s_n[k];
          c_q[k] <= c_n[k];
        end
      end
      if (ld[STAGES-1]) begin
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
